data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the byte-addressed 256-byte data memory. It accepts word-sized load/store requests from port 0 (core load/store unit) and port 1 (debug/DMA). It grants one request at a time, checks alignment and range, and drives the memory's address, data, `mem_w` and `mem_r` lines. It returns registered read data with a one-cycle `done` pulse, so the memory's combinational read path never reaches a requester directly.

---
 rtl/data_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// ----------------
// Two-port arbiter and sequencer in front of a byte-addressed data memory.
// It grants one word load/store at a time, rejects misaligned or out-of-range
// addresses, and drives the memory for one ACCESS cycle. Read data is returned
// from a register with a one-cycle done pulse, so the memory's combinational
// read path never reaches a requester.
//
// Build option: define DATA_MEM_ARB_RR_EN for round-robin arbitration on a
// conflict. When it is left undefined, port 0 always wins a conflict.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}   request inputs, held stable until done
//   done/err/rdata{0,1}      completion pulse, error flag and load data
//   busy                     high whenever the sequencer is not idle
//   mem_addr, mem_data_in    address and write data to the memory
//   mem_data_out             combinational read data from the memory
//   mem_w, mem_r             memory write / read enables (ACCESS cycle only)

module data_mem_arbiter #(
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        busy,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        mem_w,
   output logic        mem_r
);

   localparam logic [31:0] MaxAddr = 32'(MEM_BYTES - 4);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic        port_q, port_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_data_in_q, mem_data_in_d;

   logic        any_req;
   logic        grant;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_illegal;

   assign any_req = req0 | req1;

`ifdef DATA_MEM_ARB_RR_EN
   // Last granted port; resets to 1 so the first conflict goes to port 0.
   logic rr_last_q, rr_last_d;

   always_comb begin
      if (req0 && req1) begin
         grant = ~rr_last_q;
      end else begin
         grant = ~req0;
      end
   end

   always_comb begin
      rr_last_d = rr_last_q;
      if (state_q == StIdle && any_req) begin
         rr_last_d = grant;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_q <= 1'b1;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end
`else
   // Port 0 wins whenever it is requesting.
   always_comb begin
      grant = ~req0;
   end
`endif

   always_comb begin
      sel_we      = grant ? we1    : we0;
      sel_addr    = grant ? addr1  : addr0;
      sel_wdata   = grant ? wdata1 : wdata0;
      // Full 32-bit compare so high addresses never wrap into range.
      sel_illegal = (sel_addr[1:0] != 2'b00) || (sel_addr > MaxAddr);
   end

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      port_d        = port_q;
      err_d         = err_q;
      rdata_d       = rdata_q;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               we_d    = sel_we;
               port_d  = grant;
               rdata_d = '0;
               if (sel_illegal) begin
                  // Memory lines keep their old value: an errored access never touches memory.
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  err_d         = 1'b0;
                  mem_addr_d    = sel_addr;
                  mem_data_in_d = sel_wdata;
                  state_d       = StAccess;
               end
            end
         end
         StAccess: begin
            rdata_d = we_q ? 32'h0 : mem_data_out;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         we_q          <= 1'b0;
         port_q        <= 1'b0;
         err_q         <= 1'b0;
         rdata_q       <= '0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         port_q        <= port_d;
         err_q         <= err_d;
         rdata_q       <= rdata_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
      end
   end

   // Enables are gated by rst so a store caught by reset does not commit.
   assign mem_w       = (state_q == StAccess) &  we_q & ~rst;
   assign mem_r       = (state_q == StAccess) & ~we_q & ~rst;
   assign mem_addr    = mem_addr_q;
   assign mem_data_in = mem_data_in_q;
   assign busy        = (state_q != StIdle);

   assign done0  = (state_q == StDone) & ~port_q;
   assign done1  = (state_q == StDone) &  port_q;
   assign err0   = done0 & err_q;
   assign err1   = done1 & err_q;
   assign rdata0 = done0 ? rdata_q : 32'h0;
   assign rdata1 = done1 ? rdata_q : 32'h0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: a byte-array memory model, a table of
// single-port transactions, and hand-written sequences for reset during a
// store, port conflicts and back-to-back requests.

module tb_data_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, mem_clr;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        done0, done1, err0, err1, busy, mem_w, mem_r;
   logic [31:0] rdata0, rdata1, mem_addr, mem_data_in, mem_data_out;

   int tests = 0;
   int fails = 0;

   logic [7:0] mem [256];

   data_mem_arbiter #(.MEM_BYTES(256)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0         (req0),
      .req1         (req1),
      .we0          (we0),
      .we1          (we1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .done0        (done0),
      .done1        (done1),
      .err0         (err0),
      .err1         (err1),
      .rdata0       (rdata0),
      .rdata1       (rdata1),
      .busy         (busy),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .mem_w        (mem_w),
      .mem_r        (mem_r)
   );

   // Memory model: little-endian word write on the clock edge, combinational read.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (mem_w && mem_addr <= 32'd252) begin
         mem[mem_addr[7:0]]         <= mem_data_in[7:0];
         mem[mem_addr[7:0] + 8'd1]  <= mem_data_in[15:8];
         mem[mem_addr[7:0] + 8'd2]  <= mem_data_in[23:16];
         mem[mem_addr[7:0] + 8'd3]  <= mem_data_in[31:24];
      end
   end

   always_comb begin
      mem_data_out = '0;
      if (mem_addr <= 32'd252) begin
         mem_data_out = {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                         mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
      end
   end

   function automatic logic [31:0] mem_word(input int a);
      return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[8'(a)]};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " done0"},       32'(done0),  32'h0);
      check({tag, " done1"},       32'(done1),  32'h0);
      check({tag, " err0"},        32'(err0),   32'h0);
      check({tag, " err1"},        32'(err1),   32'h0);
      check({tag, " rdata0"},      rdata0,      32'h0);
      check({tag, " rdata1"},      rdata1,      32'h0);
      check({tag, " busy"},        32'(busy),   32'h0);
      check({tag, " mem_w"},       32'(mem_w),  32'h0);
      check({tag, " mem_r"},       32'(mem_r),  32'h0);
      check({tag, " mem_addr"},    mem_addr,    32'h0);
      check({tag, " mem_data_in"}, mem_data_in, 32'h0);
   endtask

   // One request on one port; lat counts cycles after the accept edge (-1 = timeout).
   task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic [31:0] rd, output bit other, output bit memact);
      lat = -1; err = 1'b0; rd = '0; other = 1'b0; memact = 1'b0;
      @(posedge clk); #1;
      if (!port) begin
         we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
      end else begin
         we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
      end
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (mem_w || mem_r) memact = 1'b1;
         if (port ? (done0 || err0 || rdata0 != 0) : (done1 || err1 || rdata1 != 0)) other = 1'b1;
         if (port ? done1 : done0) begin
            lat = c;
            err = port ? err1 : err0;
            rd  = port ? rdata1 : rdata0;
            break;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   initial begin
      int          lat;
      logic        err;
      logic [31:0] rd;
      bit          other, memact, saw;
      int          n, k, last, idle_cnt, p5;
      int          seq [4];
      int          exp_seq [4];
      bit          b2b_we [4];
      logic [31:0] b2b_addr [4];
      logic [31:0] b2b_wdata [4];
      logic [31:0] b2b_rd [4];

      //          port  we    addr           wdata          err   rdata          lat
      vecs[0]  = '{1'b0, 1'b1, 32'd8,         32'hDEADBEEF, 1'b0, 32'h0,         2};
      vecs[1]  = '{1'b0, 1'b0, 32'd8,         32'h0,        1'b0, 32'hDEADBEEF,  2};
      vecs[2]  = '{1'b1, 1'b0, 32'h6,         32'h0,        1'b1, 32'h0,         1};
      vecs[3]  = '{1'b1, 1'b1, 32'd253,       32'hFFFFFFFF, 1'b1, 32'h0,         1};
      vecs[4]  = '{1'b1, 1'b0, 32'd8,         32'h0,        1'b0, 32'hDEADBEEF,  2};
      vecs[5]  = '{1'b1, 1'b1, 32'd252,       32'hA5A50001, 1'b0, 32'h0,         2};
      vecs[6]  = '{1'b0, 1'b0, 32'd252,       32'h0,        1'b0, 32'hA5A50001,  2};
      vecs[7]  = '{1'b0, 1'b0, 32'd256,       32'h0,        1'b1, 32'h0,         1};
      vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFFFC,  32'h55555555, 1'b1, 32'h0,         1};
      vecs[9]  = '{1'b1, 1'b0, 32'd0,         32'h0,        1'b0, 32'h0,         2};
      vecs[10] = '{1'b0, 1'b1, 32'd4,         32'h11223344, 1'b0, 32'h0,         2};
      vecs[11] = '{1'b1, 1'b0, 32'd4,         32'h0,        1'b0, 32'h11223344,  2};
      vecs[12] = '{1'b1, 1'b0, 32'd2,         32'h0,        1'b1, 32'h0,         1};

      rst = 1'b1; mem_clr = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0; mem_clr = 1'b0;
      #1; check_reset("reset");

      // Table of single-port transactions.
      for (int i = 0; i < NV; i++) begin
         run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, rd, other, memact);
         check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
         check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("v%0d other port quiet", i), 32'(other), 32'h0);
         if (vecs[i].exp_err) check($sformatf("v%0d no mem access", i), 32'(memact), 32'h0);
      end
      check("mem bytes 8..11", mem_word(8), 32'hDEADBEEF);
      check("mem byte 8", 32'(mem[8]), 32'hEF);
      check("mem byte 11", 32'(mem[11]), 32'hDE);
      check("mem bytes 252..255", mem_word(252), 32'hA5A50001);

      // Reset during the ACCESS cycle of a store.
      @(posedge clk); #1;
      we0 = 1'b1; addr0 = 32'd16; wdata0 = 32'h12345678; req0 = 1'b1;
      @(posedge clk); #1;
      check("mid-store busy in access", 32'(busy), 32'h1);
      check("mid-store mem_w before rst", 32'(mem_w), 32'h1);
      rst = 1'b1; req0 = 1'b0;
      #1;
      check("mid-store mem_w gated by rst", 32'(mem_w), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid-store idle after rst", 32'(busy), 32'h0);
      saw = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done0 || done1) saw = 1'b1;
      end
      check("mid-store no done", 32'(saw), 32'h0);
      check("mid-store mem unchanged", mem_word(16), 32'h0);
      run_txn(1'b0, 1'b0, 32'd16, 32'h0, lat, err, rd, other, memact);
      check("mid-store reload latency", 32'(lat), 32'd2);
      check("mid-store reload rdata", rd, 32'h0);

      // Reset after activity; this also re-arms the round-robin pointer.
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1; check_reset("reset2");

      // Conflict: both ports hold store requests.
`ifdef DATA_MEM_ARB_RR_EN
      exp_seq = '{0, 1, 0, 1};
`else
      exp_seq = '{0, 0, 0, 0};
`endif
      seq = '{9, 9, 9, 9};
      @(posedge clk); #1;
      we0 = 1'b1; addr0 = 32'd0; wdata0 = 32'hAAAA0000;
      we1 = 1'b1; addr1 = 32'd4; wdata1 = 32'hBBBB1111;
      req0 = 1'b1; req1 = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(posedge clk); #1;
         if (done0) begin
            seq[n] = 0; n++;
         end else if (done1) begin
            seq[n] = 1; n++;
         end
      end
      req0 = 1'b0;
      for (int j = 0; j < 4; j++) check($sformatf("conflict grant %0d", j), 32'(seq[j]), 32'(exp_seq[j]));
      p5 = 9;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (done0) begin
            p5 = 0; break;
         end else if (done1) begin
            p5 = 1; break;
         end
      end
      req1 = 1'b0;
      check("conflict port1 after req0 drops", 32'(p5), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("conflict mem word 0", mem_word(0), 32'hAAAA0000);
      check("conflict mem word 4", mem_word(4), 32'hBBBB1111);

      // Back-to-back on port 0: new operands right after each done.
      b2b_we    = '{1'b1, 1'b1, 1'b0, 1'b0};
      b2b_addr  = '{32'd20, 32'd24, 32'd20, 32'd24};
      b2b_wdata = '{32'h0BADF00D, 32'hCAFE0123, 32'h0, 32'h0};
      b2b_rd    = '{32'h0, 32'h0, 32'h0BADF00D, 32'hCAFE0123};
      @(posedge clk); #1;
      k = 0; last = 0; idle_cnt = 0;
      we0 = b2b_we[0]; addr0 = b2b_addr[0]; wdata0 = b2b_wdata[0]; req0 = 1'b1;
      for (int c = 1; c <= 30 && k < 4; c++) begin
         @(posedge clk); #1;
         if (!busy) idle_cnt++;
         if (done0) begin
            check($sformatf("b2b %0d rdata", k), rdata0, b2b_rd[k]);
            check($sformatf("b2b %0d err", k), 32'(err0), 32'h0);
            if (k > 0) begin
               check($sformatf("b2b %0d interval", k), 32'(c - last), 32'd3);
               check($sformatf("b2b %0d busy low cycles", k), 32'(idle_cnt), 32'd1);
            end else begin
               check("b2b 0 latency", 32'(c), 32'd2);
            end
            last = c; idle_cnt = 0; k++;
            if (k < 4) begin
               we0 = b2b_we[k]; addr0 = b2b_addr[k]; wdata0 = b2b_wdata[k];
            end else begin
               req0 = 1'b0;
            end
         end
      end
      req0 = 1'b0;
      check("b2b all completed", 32'(k), 32'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
